// File: rtl/alu_vector_sequencer.sv
// Automatic test sequencer for the 16-bit ALU: sweeps a fixed operand table against every
// opcode and folds result+flags into a signature. Optional pause/step: SEQ_SINGLE_STEP_EN.
module alu_vector_sequencer #(
  parameter int unsigned NUM_VEC = 10,
  parameter int unsigned NUM_OPS = 16,
  parameter int unsigned SETTLE  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [3:0]  op,
  output logic [3:0]  vec_idx,
  output logic        capture,
  output logic [15:0] signature,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle, StDrive, StSettle, StCapture, StPause, StNext, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, sig_q, sig_d;
  logic [3:0]  op_q, op_d, op_cnt_q, op_cnt_d, idx_q, idx_d, cnt_q, cnt_d;
  logic        capture_q, capture_d, busy_q, busy_d, done_q, done_d;
  logic        start_q, start_edge;
  logic [31:0] tbl_entry;

  // {a, b} operand pairs
  function automatic logic [31:0] vec_table(input logic [3:0] idx);
    logic [31:0] e;
    case (idx)
      4'd0:    e = {16'hFD00, 16'h7D00};
      4'd1:    e = {16'h7FFF, 16'hFFFF};
      4'd2:    e = {16'h8000, 16'h0001};
      4'd3:    e = {16'h7D00, 16'hFD00};
      4'd4:    e = {16'h0000, 16'h0001};
      4'd5:    e = {16'h0001, 16'h7FFF};
      4'd6:    e = {16'hFFFF, 16'h0000};
      4'd7:    e = {16'h0000, 16'hFFFF};
      4'd8:    e = {16'hFFFF, 16'hFFFF};
      4'd9:    e = {16'h7FFF, 16'h0001};
      default: e = 32'h0;
    endcase
    return e;
  endfunction

  assign start_edge = start & ~start_q;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`else
  logic unused_step;
  assign unused_step = step ^ step_mode;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    op_cnt_d  = op_cnt_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    tbl_entry = vec_table(idx_q);

    case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          idx_d    = 4'd0;
          op_cnt_d = 4'd0;
          sig_d    = 16'h0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        a_d     = tbl_entry[31:16];
        b_d     = tbl_entry[15:0];
        op_d    = op_cnt_q;
        cnt_d   = 4'(SETTLE - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: begin
        sig_d = {sig_q[14:0], sig_q[15]} ^ alu_result ^ {11'b0, alu_flags};
`ifdef SEQ_SINGLE_STEP_EN
        state_d = step_mode ? StPause : StNext;
`else
        state_d = StNext;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      StPause: begin
        // Clearing step_mode releases the pause just like a step edge
        if ((step & ~step_q) || !step_mode) begin
          state_d = StNext;
        end
      end
`endif
      StNext: begin
        if (32'(op_cnt_q) < NUM_OPS - 1) begin
          op_cnt_d = op_cnt_q + 4'd1;
          state_d  = StDrive;
        end else begin
          op_cnt_d = 4'd0;
          if (32'(idx_q) == NUM_VEC - 1) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StDrive;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    capture_d = (state_d == StCapture);
    busy_d    = (state_d inside {StDrive, StSettle, StCapture, StPause, StNext});
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      a_q       <= 16'h0;
      b_q       <= 16'h0;
      op_q      <= 4'd0;
      op_cnt_q  <= 4'd0;
      idx_q     <= 4'd0;
      cnt_q     <= 4'd0;
      sig_q     <= 16'h0;
      capture_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      op_cnt_q  <= op_cnt_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      capture_q <= capture_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign vec_idx   = idx_q;
  assign capture   = capture_q;
  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: stub ALU plus a table-walk reference model of the run.
module tb_alu_vector_sequencer;

  localparam int unsigned NV         = 10;
  localparam int unsigned NO         = 16;
  localparam int unsigned ST         = 2;
  localparam int unsigned RUN_CYCLES = NV * NO * (ST + 3);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [15:0] a, b, signature;
  logic [3:0]  op, vec_idx;
  logic        capture, busy, done;

  int          checks = 0;
  int          failures = 0;
  int          stub_kind = 0;
  logic [15:0] key = 16'h0;
  logic [15:0] tab_a [NV];
  logic [15:0] tab_b [NV];

  always #5 clk = ~clk;

  alu_vector_sequencer #(
    .NUM_VEC(NV),
    .NUM_OPS(NO),
    .SETTLE (ST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .a         (a),
    .b         (b),
    .op        (op),
    .vec_idx   (vec_idx),
    .capture   (capture),
    .signature (signature),
    .busy      (busy),
    .done      (done)
  );

  // Stub ALU: {result, flags} as a deterministic function of the operands
  function automatic logic [20:0] stub(input int kind, input logic [15:0] k,
                                       input logic [15:0] x, input logic [15:0] y,
                                       input logic [3:0] o);
    logic [15:0] r;
    case (kind)
      0:       r = 16'h0000;
      1:       r = 16'h0001;
      default: r = ((x ^ k) + y) ^ {o, o, o, o};
    endcase
    return {r, (kind < 2) ? 5'd0 : (r[4:0] ^ {1'b0, o})};
  endfunction

  assign {alu_result, alu_flags} = stub(stub_kind, key, a, b, op);

  function automatic logic [15:0] fold(input logic [15:0] s, input logic [20:0] rf);
    return ((s << 1) | (s >> 15)) ^ rf[20:5] ^ {11'd0, rf[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run from a start edge; checks operands, signature and timing against the table
  task automatic run_full(input int kind, input bit poke_start, input bit smode, input string tag);
    int          n, n_cap, k_idx, k_op, first_seen;
    bit          poked;
    logic [15:0] msig;
    logic [15:0] frozen;
    stub_kind  = kind;
    key        = 16'($urandom);
    step_mode  = smode;
    msig       = 16'h0;
    n_cap      = 0;
    first_seen = -1;
    poked      = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_restart"}, {49'd0, done, busy, vec_idx, signature},
        {49'd0, 1'b0, 1'b1, 4'd0, 16'd0});
    n = 1;
    while (!done && n <= int'(RUN_CYCLES) + 20) begin
      step = 1'($urandom);
      if (poke_start && !poked && vec_idx == 4'd4) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (a == 16'h7D00 && b == 16'hFD00 && op == 4'd5 && first_seen < 0) first_seen = n;
      if (capture) begin
        k_idx = n_cap / int'(NO);
        k_op  = n_cap % int'(NO);
        if (n_cap < int'(NV * NO)) begin
          chk({tag, "_operands"}, {24'd0, a, b, op, vec_idx},
              {24'd0, tab_a[k_idx], tab_b[k_idx], 4'(k_op), 4'(k_idx)});
          chk({tag, "_sig_run"}, {48'd0, signature}, {48'd0, msig});
          if (k_idx == 3 && k_op == 5)
            chk({tag, "_hold_3_5"}, 64'(n - first_seen + 1), 64'(ST + 1));
          msig = fold(msig, stub(kind, key, tab_a[k_idx], tab_b[k_idx], 4'(k_op)));
        end
        n_cap++;
      end
      tick();
      n++;
    end
    start = 1'b0;
    step  = 1'b0;
    chk({tag, "_done_cycle"}, 64'(n), 64'(RUN_CYCLES + 1));
    chk({tag, "_captures"}, 64'(n_cap), 64'(NV * NO));
    chk({tag, "_sig_final"}, {48'd0, signature}, {48'd0, msig});
    if (kind < 2) chk({tag, "_sig_zero"}, {48'd0, signature}, 64'd0);
    frozen = signature;
    repeat (4) tick();
    chk({tag, "_done_hold"}, {24'd0, done, busy, capture, signature, a, op},
        {24'd0, 1'b1, 1'b0, 1'b0, frozen, tab_a[NV-1], 4'(NO - 1)});
  endtask

  initial begin
    int n, caps;
    tab_a = '{16'hFD00, 16'h7FFF, 16'h8000, 16'h7D00, 16'h0000,
              16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF};
    tab_b = '{16'h7D00, 16'hFFFF, 16'h0001, 16'hFD00, 16'h0001,
              16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001};

    repeat (2) tick();
    chk("reset_state", {15'd0, a, b, op, vec_idx, capture, signature, busy, done}, 64'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", {61'd0, busy, done, capture}, 64'd0);

    run_full(0, 1'b0, 1'b0, "zero_stub");
`ifdef SEQ_SINGLE_STEP_EN
    run_full(1, 1'b1, 1'b0, "const1_stub");
`else
    run_full(1, 1'b1, 1'b1, "const1_stub");
`endif

    // Reset in the middle of SETTLE
    stub_kind = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset_settle", {46'd0, a, busy, capture}, {46'd0, tab_a[0], 1'b1, 1'b0});
    reset_n = 1'b0;
    #2;
    chk("async_reset", {15'd0, a, b, op, vec_idx, capture, signature, busy, done}, 64'd0);
    tick();
    reset_n = 1'b1;
    caps = 0;
    for (int i = 0; i < 8; i++) begin
      if (capture || busy) caps++;
      tick();
    end
    chk("idle_after_abort", 64'(caps), 64'd0);

    run_full(2, 1'b0, 1'b0, "rand_stub_a");
    run_full(2, 1'b1, 1'b0, "rand_stub_b");

`ifdef SEQ_SINGLE_STEP_EN
    stub_kind = 2;
    step_mode = 1'b1;
    step      = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!capture && n < 20) begin
      tick();
      n++;
    end
    chk("step_first_cap", {63'd0, capture}, 64'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("step_pause_hold", {28'd0, a, b, op},
          {28'd0, tab_a[0], tab_b[0], 4'd0});
      chk("step_pause_flags", {62'd0, capture, busy}, {62'd0, 1'b0, 1'b1});
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    caps = 0;
    for (int i = 0; i < 15; i++) begin
      if (capture) caps++;
      tick();
    end
    chk("step_one_more_cap", 64'(caps), 64'd1);
    chk("step_op_one", {60'd0, op}, 64'd1);
    step_mode = 1'b0;
    n = 0;
    while (!done && n < int'(RUN_CYCLES) + 20) begin
      tick();
      n++;
    end
    chk("step_release_done", {63'd0, done}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
